frame_stream_tx: RTL and testbench
==================================

# frame_stream_tx

Parametrised frame streamer that reads a stored image out of a synchronous-read pixel memory and emits it as a framed byte stream on a valid/ready interface. The byte stream feeds the UART byte transmitter toward the NANO link. Each frame carries:
- a start-of-frame header;
- an 8-bit frame sequence number;
- big-endian zero-padded pixels;
- an optional 8-bit checksum trailer.

Pixel width, image size and header byte are configurable.

## Interface
- PIXEL_W, 12, bits per stored pixel (1..32)
- IMAGE_SIZE, 2500, pixels per frame (>=1)
- ADDR_W, $clog2(IMAGE_SIZE), memory address width
- SOF_BYTE, 8'hA5, first header byte
- BPP (localparam), ceil(PIXEL_W/8), bytes per pixel
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  level; a rising edge launches one frame
- abort  in  1  synchronous; cancels the frame in progress
- mem_addr  out  ADDR_W  pixel read address
- mem_rd_en  out  1  read strobe
- mem_data  in  PIXEL_W  read data, valid exactly 1 cycle after mem_rd_en
- byte_data  out  8  stream byte
- byte_valid  out  1  byte_data valid
- byte_ready  in  1  downstream accepts
- busy  out  1  frame in progress
- done  out  1  1-cycle pulse when a frame completes
- frame_cnt  out  8  number of completed frames, wraps 255->0

## Operation
- States: IDLE, HDR0, HDR1, FETCH, LOAD, SEND, TRAIL.
- **IDLE**
  - start is registered internally; a rising edge (prev 0, now 1) moves to HDR0.
  - Set pixel index to 0 and clear the checksum.
- **HDR0**: present SOF_BYTE. On accept, go to HDR1.
- **HDR1**: present frame_cnt. On accept, go to FETCH.
- **FETCH**: assert mem_rd_en for 1 cycle with mem_addr = index, then go to LOAD.
- **LOAD**
  - Capture mem_data into a shift register, zero-extended to BPP*8 bits.
  - Set byte counter to 0, then go to SEND.
- **SEND**
  - Present the most significant remaining byte; byte 0 is bits [BPP*8-1 : BPP*8-8].
  - On each accept, add the byte to the checksum (mod 256) and shift.
  - After byte BPP-1 is accepted:
    - if index < IMAGE_SIZE-1, increment index and go to FETCH;
    - otherwise go to TRAIL (checksum build) or finish (no checksum).
- **TRAIL**: present the checksum byte. On accept, finish.
- **Finish**: pulse done, increment frame_cnt, return to IDLE.
- Header bytes and the trailer are excluded from the checksum.
- A transfer occurs when byte_valid && byte_ready on a rising clk edge.
- While byte_valid=1 and byte_ready=0, byte_data is held stable.
- busy = (state != IDLE).

## Timing
- Reset values:
  - outputs: byte_valid=0, byte_data=0, mem_rd_en=0, mem_addr=0, busy=0, done=0, frame_cnt=0;
  - internal state: state=IDLE, start history=0.
- start edge sampled in cycle N: busy=1 and byte_valid=1 with SOF_BYTE in cycle N+1.
- byte_valid deasserts in the cycle after each accept, and stays low through FETCH and LOAD. This gives a 2-cycle gap between pixels and after the header.
- Within a pixel, byte k+1 is valid the cycle after byte k is accepted.
- done asserts the cycle after the final accept. frame_cnt updates in the same cycle. busy=0 in that cycle.
- start edges while busy=1 are ignored. No edge is queued.
- A start held high across frames does not relaunch; a new 0->1 edge is required.
- abort=1 in any non-IDLE state:
  - next cycle: IDLE, byte_valid=0, mem_rd_en=0;
  - no done pulse and no frame_cnt increment;
  - a byte in flight may be withdrawn (the only permitted valid drop).
- abort and final accept in the same cycle: abort wins; the frame is not counted.
- abort in IDLE: no effect.
- A start edge in the same cycle as abort is ignored.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously).

## Configuration
- FRAME_STREAM_TX_CHECKSUM_EN defined: TRAIL state is present; the frame is 2 + IMAGE_SIZE*BPP + 1 bytes.
- Undefined: TRAIL and the checksum logic are removed; after the last pixel byte the block finishes directly; the frame is 2 + IMAGE_SIZE*BPP bytes.

## Test plan
- Basic frame
  - Setup: IMAGE_SIZE=4, PIXEL_W=12, memory {F00,00F,123,ABC}, checksum on, byte_ready=1, start pulse.
  - Required bytes: A5 00 0F 00 00 0F 01 23 0A BC 08.
  - Then one done pulse and frame_cnt=1.
- Backpressure
  - Stimulus: same frame; byte_ready random 30% high.
  - Required: identical byte sequence; byte_data stable whenever valid && !ready; no accepted byte duplicated or dropped.
- Sequence wrap
  - Stimulus: 256 back-to-back frames, each launched by a fresh start edge.
  - Required: HDR1 byte runs 00..FF; after the last frame, frame_cnt=00.
- Abort and restart
  - Stimulus: abort asserted on the cycle the 5th byte is accepted; then a new start.
  - Required: byte_valid=0 next cycle, no done, frame_cnt unchanged.
  - The restarted frame begins at A5 with the same sequence number and pixel 0.
- Start while busy and held start
  - Stimulus: extra start edges mid-frame; start held high through completion.
  - Required: exactly one frame is sent; busy=0 after done.
- Checksum compiled out, 8-bit pixels
  - Setup: FRAME_STREAM_TX_CHECKSUM_EN undefined, PIXEL_W=8, IMAGE_SIZE=3, memory {11,22,33}.
  - Required bytes: A5 00 11 22 33, then done.

Source files
------------

// File: rtl/frame_stream_tx_if.sv
// Pixel-memory read port and outgoing byte stream of frame_stream_tx.
// The streamer uses the master modport; memory and byte sink use the slave modport.
interface frame_stream_tx_if #(
  parameter int PIXEL_W = 12,
  parameter int ADDR_W  = 12
);
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd_en;
  logic [PIXEL_W-1:0] mem_data;
  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               byte_ready;

  modport master (
    output mem_addr, mem_rd_en, byte_data, byte_valid,
    input  mem_data, byte_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, byte_data, byte_valid,
    output mem_data, byte_ready
  );
endinterface

// File: rtl/frame_stream_tx.sv
// Streams a stored image as SOF, sequence byte, big-endian padded pixels and an
// optional checksum trailer (enabled by defining FRAME_STREAM_TX_CHECKSUM_EN).
module frame_stream_tx #(
  parameter int         PIXEL_W    = 12,
  parameter int         IMAGE_SIZE = 2500,
  parameter int         ADDR_W     = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1,
  parameter logic [7:0] SOF_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  frame_stream_tx_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  localparam int BPP  = (PIXEL_W + 7) / 8;
  localparam int SH_W = BPP * 8;
  localparam int BC_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(IMAGE_SIZE - 1);
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BPP - 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, FETCH, LOAD, SEND, TRAIL} state_t;

  state_t            state, state_next;
  logic              start_q;
  logic [ADDR_W-1:0] idx;
  logic [SH_W-1:0]   shreg;
  logic [BC_W-1:0]   byte_cnt;
  logic              accept;
  logic              start_edge;
  logic              last_byte;
  logic              finish;
`ifdef FRAME_STREAM_TX_CHECKSUM_EN
  logic [7:0]        cksum;
`endif

  assign accept     = bus.byte_valid && bus.byte_ready;
  assign start_edge = start && !start_q;
  assign last_byte  = (byte_cnt == LAST_BYTE);

  assign bus.mem_rd_en = (state == FETCH);
  assign bus.mem_addr  = idx;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_next     = state;
    finish         = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    case (state)
      IDLE:  if (start_edge && !abort) state_next = HDR0;
      HDR0: begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = SOF_BYTE;
        if (accept) state_next = HDR1;
      end
      HDR1: begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = frame_cnt;
        if (accept) state_next = FETCH;
      end
      FETCH: state_next = LOAD;
      LOAD:  state_next = SEND;
      SEND: begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = shreg[SH_W-1 -: 8];
        if (accept && last_byte) begin
          if (idx < LAST_IDX) begin
            state_next = FETCH;
          end else begin
`ifdef FRAME_STREAM_TX_CHECKSUM_EN
            state_next = TRAIL;
`else
            state_next = IDLE;
            finish     = 1'b1;
`endif
          end
        end
      end
`ifdef FRAME_STREAM_TX_CHECKSUM_EN
      TRAIL: begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = cksum;
        if (accept) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including a final accept in the same cycle.
    if (abort && state != IDLE) begin
      state_next = IDLE;
      finish     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q   <= 1'b0;
      idx       <= '0;
      shreg     <= '0;
      byte_cnt  <= '0;
      done      <= 1'b0;
      frame_cnt <= 8'h00;
    end else begin
      start_q <= start;
      done    <= finish;
      if (finish) frame_cnt <= frame_cnt + 8'd1;
      case (state)
        IDLE: idx <= '0;
        LOAD: begin
          shreg    <= SH_W'(bus.mem_data);
          byte_cnt <= '0;
        end
        SEND: begin
          if (accept && !abort) begin
            shreg    <= shreg << 8;
            byte_cnt <= byte_cnt + BC_W'(1);
            if (last_byte && idx < LAST_IDX) idx <= idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_STREAM_TX_CHECKSUM_EN
  // Only pixel bytes contribute; header and trailer are excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 cksum <= 8'h00;
    else if (state == IDLE)                   cksum <= 8'h00;
    else if (state == SEND && accept && !abort) cksum <= cksum + bus.byte_data;
  end
`endif

endmodule

// File: tb/tb_frame_stream_tx.sv
// Directed/randomized bench for frame_stream_tx with a queue-based frame model
// (IMAGE_SIZE=4, PIXEL_W=12); follows FRAME_STREAM_TX_CHECKSUM_EN when defined.
module tb_frame_stream_tx;
  localparam int         PIXEL_W    = 12;
  localparam int         IMAGE_SIZE = 4;
  localparam int         ADDR_W     = 2;
  localparam int         BPP        = (PIXEL_W + 7) / 8;
  localparam logic [7:0] SOF        = 8'hA5;
`ifdef FRAME_STREAM_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 2 + IMAGE_SIZE * BPP + 1;
`else
  localparam int FRAME_LEN = 2 + IMAGE_SIZE * BPP;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ready = 1'b0;
  logic       busy, done;
  logic [7:0] frame_cnt;

  frame_stream_tx_if #(.PIXEL_W(PIXEL_W), .ADDR_W(ADDR_W)) bus ();

  frame_stream_tx #(
    .PIXEL_W(PIXEL_W), .IMAGE_SIZE(IMAGE_SIZE), .ADDR_W(ADDR_W), .SOF_BYTE(SOF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  logic [PIXEL_W-1:0] mem [IMAGE_SIZE];
  assign bus.byte_ready = ready;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_data <= mem[bus.mem_addr];

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         last_done_cyc = 0;
  int         base;
  logic [7:0] exp_cnt = 8'h00;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] basic_exp[$];
  logic       abt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rand_ready(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // Reference frame: bytes and their cycle offsets with an always-ready sink.
  task automatic make_expected(input logic [7:0] seq);
    logic [7:0] sum;
    logic [7:0] b;
    int         t;
    sum = 8'h00;
    exp_q = {};
    exp_t = {};
    exp_q.push_back(SOF); exp_t.push_back(0);
    exp_q.push_back(seq); exp_t.push_back(1);
    t = 1;
    for (int p = 0; p < IMAGE_SIZE; p++) begin
      for (int k = BPP - 1; k >= 0; k--) begin
        b = 8'((32'(mem[p]) >> (8 * k)) & 32'hFF);
        t = (k == BPP - 1) ? t + 3 : t + 1;
        exp_q.push_back(b);
        exp_t.push_back(t);
        sum = sum + b;
      end
    end
`ifdef FRAME_STREAM_TX_CHECKSUM_EN
    exp_q.push_back(sum);
    exp_t.push_back(t + 1);
`endif
  endtask

  // One clock: apply inputs at the falling edge, log the transfer, sample after the next fall.
  task automatic drive_cycle(input logic rdy, input logic abt_in);
    logic       stall;
    logic [7:0] held;
    ready = rdy;
    abort = abt_in;
    if (bus.byte_valid && rdy) begin
      rx_q.push_back(bus.byte_data);
      rx_t.push_back(cyc);
    end
    stall = bus.byte_valid && !rdy && !abt_in;
    held  = bus.byte_data;
    @(negedge clk);
    cyc++;
    abort = 1'b0;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (stall) begin
      check("stall_valid", 32'(bus.byte_valid), 32'd1);
      check("stall_data", 32'(bus.byte_data), 32'(held));
    end
  endtask

  task automatic launch(input bit hold);
    rx_q = {};
    rx_t = {};
    start = 1'b1;
    drive_cycle(1'b1, 1'b0);
    check("sof_busy", 32'(busy), 32'd1);
    check("sof_valid", 32'(bus.byte_valid), 32'd1);
    check("sof_data", 32'(bus.byte_data), 32'(SOF));
    if (!hold) start = 1'b0;
  endtask

  task automatic run_to_done(input int pct, input bit toggle);
    int b0;
    b0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == b0; i++) begin
      if (toggle) start = (rx_q.size() < FRAME_LEN - 3) ? ~start : 1'b1;
      drive_cycle(rand_ready(pct), 1'b0);
    end
    check("done_seen", 32'(done_cnt - b0), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_cycle", 32'(last_done_cyc), 32'(rx_t[$] + 1));
    exp_cnt = exp_cnt + 8'd1;
    check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
  endtask

  task automatic compare_stream(input logic [7:0] seq);
    make_expected(seq);
    check("frame_len", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.byte_valid), 32'd0);
    check("rst_data", 32'(bus.byte_data), 32'd0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b1;
    drive_cycle(1'b1, 1'b0);

    // Basic frame against the literal byte list and the model's cycle offsets.
    mem[0] = 12'hF00; mem[1] = 12'h00F; mem[2] = 12'h123; mem[3] = 12'hABC;
    basic_exp = '{8'hA5, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h01, 8'h23, 8'h0A, 8'hBC};
`ifdef FRAME_STREAM_TX_CHECKSUM_EN
    basic_exp.push_back(8'h08);
`endif
    launch(1'b0);
    run_to_done(100, 1'b0);
    check("basic_len", 32'(rx_q.size()), 32'(basic_exp.size()));
    for (int i = 0; i < basic_exp.size() && i < rx_q.size(); i++)
      check($sformatf("basic_byte%0d", i), 32'(rx_q[i]), 32'(basic_exp[i]));
    make_expected(8'h00);
    for (int i = 0; i < exp_t.size() && i < rx_t.size(); i++)
      check($sformatf("basic_time%0d", i), 32'(rx_t[i] - rx_t[0]), 32'(exp_t[i]));
    drive_cycle(1'b1, 1'b0);
    check("done_width", 32'(done), 32'd0);

    // Backpressure on the same image, then on random images.
    launch(1'b0);
    run_to_done(30, 1'b0);
    compare_stream(exp_cnt - 8'd1);
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < IMAGE_SIZE; p++) mem[p] = PIXEL_W'($urandom);
      launch(1'b0);
      run_to_done(50, 1'b0);
      compare_stream(exp_cnt - 8'd1);
    end

    // Abort on the 5th accept, then restart with the same sequence number.
    base = done_cnt;
    launch(1'b0);
    for (int i = 0; i < 100; i++) begin
      abt = bus.byte_valid && (rx_q.size() == 4);
      drive_cycle(1'b1, abt);
      if (abt) break;
    end
    check("abort_valid", 32'(bus.byte_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_en", 32'(bus.mem_rd_en), 32'd0);
    repeat (5) drive_cycle(1'b1, 1'b0);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    check("abort_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    launch(1'b0);
    run_to_done(100, 1'b0);
    compare_stream(exp_cnt - 8'd1);

    // Abort coinciding with the final accept: abort wins.
    base = done_cnt;
    launch(1'b0);
    for (int i = 0; i < 100; i++) begin
      abt = bus.byte_valid && (rx_q.size() == FRAME_LEN - 1);
      drive_cycle(1'b1, abt);
      if (abt) break;
    end
    check("abort_last_done", 32'(done), 32'd0);
    drive_cycle(1'b1, 1'b0);
    check("abort_last_count", 32'(done_cnt - base), 32'd0);
    check("abort_last_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Start edges while busy, start held high through completion: one frame only.
    base = done_cnt;
    launch(1'b1);
    run_to_done(100, 1'b1);
    repeat (20) drive_cycle(1'b1, 1'b0);
    check("held_one_done", 32'(done_cnt - base), 32'd1);
    check("held_len", 32'(rx_q.size()), 32'(FRAME_LEN));
    check("held_busy", 32'(busy), 32'd0);
    start = 1'b0;
    drive_cycle(1'b1, 1'b0);

    // Asynchronous reset mid-frame.
    launch(1'b0);
    repeat (5) drive_cycle(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(bus.byte_valid), 32'd0);
    check("arst_data", 32'(bus.byte_data), 32'd0);
    check("arst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("arst_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 8'h00;
    drive_cycle(1'b1, 1'b0);

    // Sequence wrap: 256 frames, HDR1 must run 00..FF.
    for (int f = 0; f < 256; f++) begin
      for (int p = 0; p < IMAGE_SIZE; p++) mem[p] = PIXEL_W'($urandom);
      launch(1'b0);
      run_to_done(70, 1'b0);
      compare_stream(8'(f));
    end
    check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
